l2recv: RTL

- L2 bus receiver: the receive side of the 8-cycle-slot snooping bus that the L2 transmitter drives.
- Watches every bus slot and captures FLUSH responses addressed to this L2 into a line buffer.
- Streams that line to l2data as 8 beats.
- Queues foreign coherence commands (BUSRD/BUSRDX/BUSUPGR) for l2tag.
- Asserts l2_bus_nack in cycle 7 of a slot when it cannot accept.

---
 rtl/l2recv_pkg.sv | 31 +++
 rtl/l2recv_snoopq.sv | 49 ++++
 rtl/l2recv.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/l2recv_pkg.sv
// rtl/l2recv_pkg.sv - bus command encodings, agent ids and shared types for l2recv
package l2recv_pkg;

  localparam int SLOT_LEN = 8;
  localparam logic [2:0] LAST_CYCLE = 3'(SLOT_LEN - 1);

  localparam logic [2:0] CMD_BUSRD   = 3'd1;
  localparam logic [2:0] CMD_BUSRDX  = 3'd2;
  localparam logic [2:0] CMD_BUSUPGR = 3'd3;
  localparam logic [2:0] CMD_FLUSH   = 3'd4;

  localparam logic [1:0] BUSID_L2 = 2'd2;

  typedef enum logic [1:0] {
    SLOT_IGNORE,
    SLOT_FILL,
    SLOT_FILL_BUSY,
    SLOT_SNOOP
  } slot_kind_e;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [4:0]  tag;
    logic [25:0] addr;
  } snoop_entry_t;

  function automatic logic is_snoop_cmd(input logic [2:0] cmd);
    return (cmd == CMD_BUSRD) || (cmd == CMD_BUSRDX) || (cmd == CMD_BUSUPGR);
  endfunction

endpackage

// File: rtl/l2recv_snoopq.sv
// rtl/l2recv_snoopq.sv - 2-entry FIFO of foreign coherence commands for l2tag
module l2recv_snoopq
  import l2recv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  snoop_entry_t push_entry,
  input  logic         pop,
  output snoop_entry_t head,
  output logic         full,
  output logic         empty
);

  snoop_entry_t entries [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push & (~full | do_pop);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/l2recv.sv
// rtl/l2recv.sv - L2 bus receiver: captures FLUSH fills, queues foreign snoops, nacks when full
module l2recv
  import l2recv_pkg::*;
#(
  parameter logic [1:0] BUSID = BUSID_L2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic [2:0]  bus_cmd,
  input  logic [4:0]  bus_tag,
  input  logic [25:0] bus_addr,
  input  logic [63:0] bus_data,
  input  logic        bus_l2_grant,
  input  logic        bus_nack,
  output logic        l2_bus_nack,
  output logic        l2recv_fill_valid,
  output logic [2:0]  l2recv_fill_tag,
  output logic [25:0] l2recv_fill_addr,
  output logic [63:0] l2recv_fill_data,
  output logic        l2recv_fill_last,
  input  logic        l2data_fill_ready,
  output logic        l2recv_snoop_valid,
  output logic [2:0]  l2recv_snoop_cmd,
  output logic [4:0]  l2recv_snoop_tag,
  output logic [25:0] l2recv_snoop_addr,
  input  logic        l2tag_snoop_ready,
  output logic        l2recv_idle
);

  logic [2:0]   bus_cycle_r;
  logic         own_slot_r;
  logic         capturing_r;
  slot_kind_e   kind_r;
  slot_kind_e   kind_next;
  snoop_entry_t slot_r;
  logic [2:0]   fill_tag_r;
  logic [25:0]  fill_addr_r;
  logic         fill_valid_r;
  logic [2:0]   fill_idx_r;
  logic [63:0]  line_buf [SLOT_LEN];

  logic         slot_start;
  logic         slot_end;
  logic         buf_we;
  logic         q_push;
  logic         q_pop;
  logic         q_full;
  logic         q_empty;
  snoop_entry_t q_head;

  assign slot_start = (bus_cycle_r == 3'd0);
  assign slot_end   = (bus_cycle_r == LAST_CYCLE);

  always_comb begin
    kind_next = SLOT_IGNORE;
    if (bus_valid && !own_slot_r) begin
      if (bus_cmd == CMD_FLUSH && bus_tag[4:3] == BUSID)
        kind_next = fill_valid_r ? SLOT_FILL_BUSY : SLOT_FILL;
      else if (is_snoop_cmd(bus_cmd) && bus_tag[4:3] != BUSID)
        kind_next = SLOT_SNOOP;
    end
  end

  assign q_pop = ~q_empty & l2tag_snoop_ready;

  always_comb begin
    l2_bus_nack = 1'b0;
    q_push      = 1'b0;
    if (slot_end) begin
      case (kind_r)
        SLOT_FILL_BUSY: l2_bus_nack = 1'b1;
        SLOT_SNOOP: begin
          if (q_full && !q_pop) l2_bus_nack = 1'b1;
          else if (!bus_nack)   q_push = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_cycle_r  <= 3'd0;
      own_slot_r   <= 1'b0;
      capturing_r  <= 1'b0;
      kind_r       <= SLOT_IGNORE;
      slot_r       <= '0;
      fill_tag_r   <= 3'd0;
      fill_addr_r  <= 26'd0;
      fill_valid_r <= 1'b0;
      fill_idx_r   <= 3'd0;
    end else begin
      bus_cycle_r <= bus_cycle_r + 3'd1;
      if (slot_end) own_slot_r <= bus_l2_grant;
      if (slot_start) begin
        kind_r <= kind_next;
        slot_r <= '{cmd: bus_cmd, tag: bus_tag, addr: bus_addr};
        if (kind_next == SLOT_FILL) begin
          capturing_r <= 1'b1;
          fill_tag_r  <= bus_tag[2:0];
          fill_addr_r <= bus_addr;
        end
      end
      // a fill nacked by anyone on the bus is dropped: the line was not transferred
      if (slot_end && capturing_r) begin
        capturing_r <= 1'b0;
        if (!bus_nack) begin
          fill_valid_r <= 1'b1;
          fill_idx_r   <= 3'd0;
        end
      end
      if (fill_valid_r && l2data_fill_ready) begin
        fill_idx_r <= fill_idx_r + 3'd1;
        if (fill_idx_r == LAST_CYCLE) fill_valid_r <= 1'b0;
      end
    end
  end

  assign buf_we = (slot_start && kind_next == SLOT_FILL) || (capturing_r && !slot_start);

  always_ff @(posedge clk) begin
    if (buf_we) line_buf[bus_cycle_r] <= bus_data;
  end

  l2recv_snoopq u_snoopq (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (slot_r),
    .pop        (q_pop),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign l2recv_fill_valid  = fill_valid_r;
  assign l2recv_fill_tag    = fill_tag_r;
  assign l2recv_fill_addr   = fill_addr_r;
  assign l2recv_fill_data   = line_buf[fill_idx_r];
  assign l2recv_fill_last   = (fill_idx_r == LAST_CYCLE);
  assign l2recv_snoop_valid = ~q_empty;
  assign l2recv_snoop_cmd   = q_head.cmd;
  assign l2recv_snoop_tag   = q_head.tag;
  assign l2recv_snoop_addr  = q_head.addr;
  assign l2recv_idle        = ~capturing_r & ~fill_valid_r & q_empty;

endmodule
